// File: rtl/tt_restoring_divider3_pkg.sv
// ---------------------------------------------------------------------------
// tt_restoring_divider3_pkg
// Shared definitions for the 3-bit sequential restoring divider:
//   - datapath width W
//   - FSM state encoding (IDLE / RUN / DONE)
//   - bit positions of every function packed into the 8-in / 8-out
//     Tiny Tapeout pin shell
// ---------------------------------------------------------------------------
package tt_restoring_divider3_pkg;

    localparam int W    = 3;
    localparam int IO_W = 8;

    // io_in bit positions
    localparam int IN_CLK      = 0;
    localparam int IN_RST_N    = 1;
    localparam int IN_LOAD_A   = 2;
    localparam int IN_LOAD_B   = 3;
    localparam int IN_CLR      = 4;
    localparam int IN_DATA_LSB = 5;

    // io_out bit positions
    localparam int OUT_Q_LSB = 0;
    localparam int OUT_R_LSB = 3;
    localparam int OUT_BUSY  = 6;
    localparam int OUT_DONE  = 7;

    // Iteration counter start value: cnt counts 2,1,0 -> three quotient bits
    localparam logic [1:0] CNT_START = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tt_restoring_divider3_if.sv
// ---------------------------------------------------------------------------
// tt_restoring_divider3_if
// Pin-shell bundle of the divider tile.
//   io_in[7:0]  : clk, rst_n, load_a, load_b, clr, data[2:0]
//   io_out[7:0] : quotient[2:0], remainder[2:0], busy, done
// Modports:
//   master - the tester side, drives io_in and observes io_out
//   slave  - the divider side, samples io_in and drives io_out
// ---------------------------------------------------------------------------
interface tt_restoring_divider3_if;
    import tt_restoring_divider3_pkg::*;

    logic [IO_W-1:0] io_in;
    logic [IO_W-1:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);

endinterface

// File: rtl/tt_restoring_divider3_div_step.sv
// ---------------------------------------------------------------------------
// tt_restoring_divider3_div_step
// One combinational restoring-division iteration.
// Ports:
//   i_r   [W:0]   current partial remainder
//   i_bit         next dividend bit shifted into the remainder
//   i_b   [W-1:0] divisor
//   o_r   [W:0]   next partial remainder
//   o_bit         quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module tt_restoring_divider3_div_step
    import tt_restoring_divider3_pkg::*;
(
    input  logic [W:0]   i_r,
    input  logic         i_bit,
    input  logic [W-1:0] i_b,
    output logic [W:0]   o_r,
    output logic         o_bit
);

    logic [W+1:0] w_rs_wide;
    logic [W:0]   w_rs;
    logic         w_ge;

    // Shift and compare. The compare sees the full shifted value so that a
    // set top remainder bit can never be mistaken for a smaller value; in
    // normal operation that bit is always zero because R < B.
    always_comb begin
        w_rs_wide = {i_r, i_bit};
        w_rs      = w_rs_wide[W:0];
        w_ge      = (w_rs_wide >= {2'b00, i_b});
        if (w_ge) begin
            o_r   = w_rs - {1'b0, i_b};
            o_bit = 1'b1;
        end else begin
            o_r   = w_rs;
            o_bit = 1'b0;
        end
    end

endmodule

// File: rtl/tt_restoring_divider3.sv
// ---------------------------------------------------------------------------
// tt_restoring_divider3
// 3-bit unsigned sequential restoring divider in the Tiny Tapeout shell.
// One quotient bit per clock; result valid three edges after load_b.
// Ports (through bus, slave modport):
//   io_in[0]    clk        io_in[1]   rst_n (async, active low)
//   io_in[2]    load_a     io_in[3]   load_b (captures divisor, starts)
//   io_in[4]    clr        io_in[7:5] data
//   io_out[2:0] quotient   io_out[5:3] remainder
//   io_out[6]   busy       io_out[7]   done
// Divide by zero is not special-cased: it yields quotient=7,
// remainder=dividend.
// ---------------------------------------------------------------------------
module tt_restoring_divider3 (
    tt_restoring_divider3_if.slave bus
);
    import tt_restoring_divider3_pkg::*;

    logic         w_clk;
    logic         w_rst_n;
    logic         w_load_a;
    logic         w_load_b;
    logic         w_clr;
    logic [W-1:0] w_data;

    assign w_clk    = bus.io_in[IN_CLK];
    assign w_rst_n  = bus.io_in[IN_RST_N];
    assign w_load_a = bus.io_in[IN_LOAD_A];
    assign w_load_b = bus.io_in[IN_LOAD_B];
    assign w_clr    = bus.io_in[IN_CLR];
    assign w_data   = bus.io_in[IN_DATA_LSB +: W];

    state_t       r_state;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_q;
    logic [W:0]   r_r;
    logic [1:0]   r_cnt;
    logic         r_busy;
    logic         r_done;

    logic [W:0]      w_r_next;
    logic            w_q_bit;
    logic [IO_W-1:0] w_out;

    // The dividend MSB still sitting in Q[2] is the bit shifted in next.
    tt_restoring_divider3_div_step u_div_step (
        .i_r   (r_r),
        .i_bit (r_q[W-1]),
        .i_b   (r_b),
        .o_r   (w_r_next),
        .o_bit (w_q_bit)
    );

    // Control FSM, operand registers and shift-subtract datapath.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_q     <= {W{1'b0}};
            r_r     <= {(W+1){1'b0}};
            r_cnt   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_load_a) begin
                        r_a <= w_data;
                    end
                    // load_b wins over clr so a DONE tile can restart directly
                    if (w_load_b) begin
                        r_b     <= w_data;
                        r_q     <= w_load_a ? w_data : r_a;
                        r_r     <= {(W+1){1'b0}};
                        r_cnt   <= CNT_START;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else if (w_clr && (r_state == ST_DONE)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Strobes are deliberately ignored while iterating.
                    r_r   <= w_r_next;
                    r_q   <= {r_q[W-2:0], w_q_bit};
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Pin mapping of the registered result and status; R[3] is not exported.
    always_comb begin
        w_out                     = {IO_W{1'b0}};
        w_out[OUT_Q_LSB +: W]     = r_q;
        w_out[OUT_R_LSB +: W]     = r_r[W-1:0];
        w_out[OUT_BUSY]           = r_busy;
        w_out[OUT_DONE]           = r_done;
    end

    assign bus.io_out = w_out;

endmodule

// File: doc/tt_restoring_divider3.md
Name: tt_restoring_divider3

Overview:
Sequential 3-bit unsigned restoring divider. It is the inverse-arithmetic companion to the team's 3-bit ripple adder tile: it computes by repeated shift-and-subtract, one quotient bit per clock.
It packs into the standard Tiny Tapeout user-module shell of 8 in and 8 out, with clock and reset taken from io_in.
Operands load through a shared 3-bit data bus with two load strobes. Results are registered on io_out with busy/done status.

Parameters:
None. Width is fixed at 3 by the pin budget; internal localparam W=3.

Ports:
io_in[0]  input  1  clk; single clock, all state on rising edge
io_in[1]  input  1  rst_n; asynchronous, active-low reset
io_in[2]  input  1  load_a; capture dividend from data
io_in[3]  input  1  load_b; capture divisor from data and start division
io_in[4]  input  1  clr; acknowledge result, return DONE->IDLE
io_in[7:5]  input  3  data; operand bus
io_out[2:0]  output  3  quotient
io_out[5:3]  output  3  remainder
io_out[6]  output  1  busy
io_out[7]  output  1  done

Behaviour:
- Reset (rst_n=0, async): state=IDLE; A,B,Q,R,cnt=0; all io_out bits 0. Reset mid-RUN aborts with no partial result visible.
- Registers:
  - A[2:0] dividend, B[2:0] divisor.
  - Q[2:0] shift register: holds the dividend, then accumulates quotient bits.
  - R[3:0] partial remainder; the 4th bit absorbs the shift.
  - cnt[1:0].
- States: IDLE, RUN, DONE.
- IDLE/DONE:
  - load_a=1: A<=data.
  - load_b=1: B<=data; Q<=(load_a ? data : A); R<=0; cnt<=2; ->RUN; done<=0.
  - load_a and load_b in the same cycle: both capture the same data, and the division uses it as the dividend.
- RUN, each cycle:
  - Rs={R[2:0],Q[2]}.
  - If Rs>=B: R<=Rs-B and the new bit is 1; else R<=Rs and the new bit is 0.
  - Q<={Q[1:0],bit}; cnt<=cnt-1.
  - When cnt==0 in RUN, go to DONE.
- load_a, load_b and clr are ignored in RUN; the divisor cannot change mid-operation.
- Latency: load_b sampled at edge k -> busy=1 after edge k. Iterations run at edges k+1..k+3. done=1 and results valid after edge k+3; busy=0 at the same edge.
- DONE:
  - Outputs hold the result.
  - clr=1 -> IDLE, done<=0, quotient/remainder hold their values.
  - load_b in DONE restarts directly; it has priority over clr.
- Outputs are registered:
  - quotient=Q, remainder=R[2:0].
  - R[3] is always 0 after a completed division, because remainder < divisor <= 7.
- Divide by zero: no special case. The algorithm naturally yields quotient=7, remainder=dividend, and done asserts normally. This is the defined behaviour.
- Input sampling: no synchronizers. Strobes are sampled level-sensitive at each rising edge, and the tester holds them for whole cycles.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), W=3, and io_in/io_out bit-index constants.
- One natural sub-module: div_step (combinational). It takes R, the shifted-in bit and B, and returns the next R and the quotient bit, using a 4-bit subtract and compare.
- The top level holds the FSM, registers and pin mapping.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle, with no clock edge -> io_out=8'h00 immediately. Release, idle 2 cycles -> io_out stays 0.
- Basic divide: load_a data=7, then load_b data=2.
  - busy=1 for 3 cycles.
  - After the 3rd edge: quotient=3, remainder=1, done=1, busy=0, so io_out=8'b1000_1011.
- Simultaneous load, data=5 with load_a=load_b=1 -> 5/5 gives quotient=1, remainder=0 after 3 edges.
- Divide by zero: A=6, B=0 -> quotient=7, remainder=6, done=1 after 3 edges.
- Ignored inputs: during RUN of 6/3, pulse load_a data=1, load_b data=1 and clr -> result is still quotient=2, remainder=0.
  - Then clr -> done=0 with results held.
  - Then load_b data=4 (A still 6) -> quotient=1, remainder=2.
- Reset mid-RUN: assert rst_n=0 after 1 iteration of 7/3 -> io_out=0 and state IDLE. A fresh 7/3 then gives quotient=2, remainder=1.
- Exhaustive sweep: all 64 (A,B) pairs against the reference model q=A/B, r=A%B, with B=0 giving q=7, r=A. Check 3-cycle latency on every pair.
